// File: rtl/rom_prog_loader_if.sv
// Byte-stream valid/ready channel feeding the ROM programming loader.
// master drives bytes (e.g. UART RX side), slave consumes them.
interface rom_prog_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/rom_prog_loader.sv
// Packs a little-endian byte stream into words and writes them to the ROM.
// Define ROM_LOADER_CHECKSUM_EN to require a mod-256 sum trailer byte.
module rom_prog_loader #(
  parameter int WIDTH     = 32,
  parameter int MEM_WORDS = 4096,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] len_i,
  rom_prog_loader_if.slave byte_if,
  output logic             wr_en_o,
  output logic [WIDTH-1:0] wr_addr_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             cpu_hold_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int BYTES = WIDTH / 8;
  localparam int BW    = $clog2(BYTES);
  localparam logic [WIDTH-1:0] MEM_W = WIDTH'(MEM_WORDS);
  localparam logic [BW-1:0]    LAST  = BW'(BYTES - 1);

`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_len;
  logic [WIDTH-1:0] r_word_idx;
  logic [BW-1:0]    r_byte_idx;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_err;

  logic             w_ready;
  logic             w_accept;
  logic             w_last_word;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_idx_inc;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  assign w_ready = (r_state == S_RECV) ||
                   (r_state == S_CHK);
`else
  assign w_ready = (r_state == S_RECV);
`endif

  assign w_accept    = byte_if.byte_valid & w_ready;
  assign w_idx_inc   = r_word_idx + WIDTH'(1);
  assign w_last_word = (w_idx_inc == r_len);

  // Current word with the incoming byte merged at its lane
  always_comb begin
    w_word = r_word;
    w_word[{r_byte_idx, 3'b000} +: 8] =
      byte_if.byte_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0)
            w_next = S_DONE;
          else if (len_i <= MEM_W)
            w_next = S_RECV;
        end
      end
      S_RECV: begin
        if (w_accept && r_byte_idx == LAST)
          w_next = S_WRITE;
      end
      S_WRITE: begin
        if (!w_last_word)
          w_next = S_RECV;
        else
`ifdef ROM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_DONE;
`endif
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start_i) begin
        if (len_i > MEM_W) begin
          r_err <= 1'b1;
        end else begin
          r_err      <= 1'b0;
          r_len      <= len_i;
          r_word_idx <= '0;
          r_byte_idx <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          r_sum      <= '0;
`endif
        end
      end
      if (r_state == S_RECV && w_accept) begin
        r_word     <= w_word;
        r_byte_idx <= r_byte_idx + BW'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
        r_sum      <= r_sum + byte_if.byte_data;
`endif
        if (r_byte_idx == LAST) begin
          r_wr_data <= w_word;
          r_wr_addr <= BASE_ADDR +
                       (r_word_idx << BW);
        end
      end
      if (r_state == S_WRITE)
        r_word_idx <= w_idx_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
      if (r_state == S_CHK && w_accept &&
          byte_if.byte_data != r_sum)
        r_err <= 1'b1;
`endif
    end
  end

  assign byte_if.byte_ready = w_ready;
  assign wr_en_o    = (r_state == S_WRITE);
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign busy_o     = (r_state != S_IDLE);
  assign cpu_hold_o = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign err_o      = r_err;

endmodule

// File: tb/tb_rom_prog_loader.sv
// Directed bench for rom_prog_loader: per-cycle vector table for a
// two-word load plus hand sequences for length, reset and trailer cases.
module tb_rom_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] len_i = '0;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  rom_prog_loader_if bus ();

  rom_prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .len_i      (len_i),
    .byte_if    (bus),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [31:0] ln;
    logic        vl;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_cnt++;
      last_addr = wr_addr_o;
      last_data = wr_data_o;
    end
  end

  function automatic vec_t v(
    logic st, logic [31:0] ln, logic vl,
    logic [7:0] d, logic rdy, logic we,
    logic [31:0] a, logic [31:0] wd,
    logic hold, logic done, logic err);
    vec_t r;
    r.st = st; r.ln = ln; r.vl = vl; r.d = d;
    r.rdy = rdy; r.we = we; r.a = a; r.wd = wd;
    r.hold = hold; r.done = done; r.err = err;
    return r;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic check_idle(string nm);
    chk({nm, " busy"}, 32'(busy_o), 0);
    chk({nm, " hold"}, 32'(cpu_hold_o), 0);
    chk({nm, " ready"}, 32'(bus.byte_ready), 0);
    chk({nm, " wr_en"}, 32'(wr_en_o), 0);
    chk({nm, " done"}, 32'(done_o), 0);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic push(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL push timeout: ready=0 expected 1");
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic start(input logic [31:0] ln);
    start_i = 1'b1;
    len_i   = ln;
    @(negedge clk);
    start_i = 1'b0;
    len_i   = '0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done seen"}, 32'(done_o), 1);
    chk({nm, " hold in done"}, 32'(cpu_hold_o), 1);
    @(negedge clk);
    chk({nm, " done width"}, 32'(done_o), 0);
    chk({nm, " hold drop"}, 32'(cpu_hold_o), 0);
  endtask

  initial begin
    vec_t tbl[11];
    int w0;

    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    tbl[0]  = v(1, 2, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 1, 8'h78, 1, 0, 0, 0, 1, 0, 0);
    tbl[2]  = v(0, 0, 1, 8'h56, 1, 0, 0, 0, 1, 0, 0);
    tbl[3]  = v(0, 0, 1, 8'h34, 1, 0, 0, 0, 1, 0, 0);
    tbl[4]  = v(0, 0, 1, 8'h12, 1, 0, 0, 0, 1, 0, 0);
    tbl[5]  = v(0, 0, 1, 8'hEF, 0, 1, 0, 32'h12345678, 1, 0, 0);
    tbl[6]  = v(0, 0, 1, 8'hEF, 1, 0, 0, 32'h12345678, 1, 0, 0);
    tbl[7]  = v(0, 0, 1, 8'hBE, 1, 0, 0, 32'h12345678, 1, 0, 0);
    tbl[8]  = v(0, 0, 1, 8'hAD, 1, 0, 0, 32'h12345678, 1, 0, 0);
    tbl[9]  = v(0, 0, 1, 8'hDE, 1, 0, 0, 32'h12345678, 1, 0, 0);
    tbl[10] = v(0, 0, 0, 8'h00, 0, 1, 4, 32'hDEADBEEF, 1, 0, 0);

    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset err", 32'(err_o), 0);
    chk("reset addr", wr_addr_o, 0);
    chk("reset data", wr_data_o, 0);
    rst_n = 1'b1;

    // Two-word load, byte_valid held across the WRITE cycle
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d ready", i), 32'(bus.byte_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d wr_en", i), 32'(wr_en_o), 32'(tbl[i].we));
      chk($sformatf("v%0d addr", i), wr_addr_o, tbl[i].a);
      chk($sformatf("v%0d data", i), wr_data_o, tbl[i].wd);
      chk($sformatf("v%0d hold", i), 32'(cpu_hold_o), 32'(tbl[i].hold));
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(tbl[i].hold));
      chk($sformatf("v%0d done", i), 32'(done_o), 32'(tbl[i].done));
      chk($sformatf("v%0d err", i), 32'(err_o), 32'(tbl[i].err));
      start_i        = tbl[i].st;
      len_i          = tbl[i].ln;
      bus.byte_valid = tbl[i].vl;
      bus.byte_data  = tbl[i].d;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("t1 chk ready", 32'(bus.byte_ready), 1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h4C;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("t1 done", 32'(done_o), 1);
    chk("t1 err", 32'(err_o), 0);
`else
    @(negedge clk);
    chk("t1 done", 32'(done_o), 1);
    chk("t1 hold", 32'(cpu_hold_o), 1);
    chk("t1 wr_en off", 32'(wr_en_o), 0);
`endif
    @(negedge clk);
    check_idle("t1 end");
    chk("t1 addr hold", wr_addr_o, 32'h4);
    chk("t1 data hold", wr_data_o, 32'hDEADBEEF);
    chk("t1 writes", 32'(wr_cnt), 2);

    // Zero-length load
    w0 = wr_cnt;
    start(0);
    chk("t2 done", 32'(done_o), 1);
    chk("t2 busy", 32'(busy_o), 1);
    chk("t2 err", 32'(err_o), 0);
    @(negedge clk);
    check_idle("t2 end");
    chk("t2 no write", 32'(wr_cnt), 32'(w0));

    // Oversize length rejected, sticky until next accepted start
    start(4097);
    chk("t3 err", 32'(err_o), 1);
    check_idle("t3 reject");
    @(negedge clk);
    chk("t3 err sticky", 32'(err_o), 1);
    w0 = wr_cnt;
    start(1);
    chk("t3 err clr", 32'(err_o), 0);
    chk("t3 ready", 32'(bus.byte_ready), 1);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
`ifdef ROM_LOADER_CHECKSUM_EN
    push(8'hAA);
`endif
    wait_done("t3");
    chk("t3 addr", last_addr, 32'h0);
    chk("t3 data", last_data, 32'h44332211);
    chk("t3 writes", 32'(wr_cnt - w0), 1);

    // Reset in mid-word, then a clean single-word load
    start(3);
    push(8'h5A);
    push(8'hA5);
    #2 rst_n = 1'b0;
    #1;
    check_idle("t5 rst");
    chk("t5 rst err", 32'(err_o), 0);
    chk("t5 rst addr", wr_addr_o, 0);
    chk("t5 rst data", wr_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wr_cnt;
    start(1);
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    push(8'hD4);
`ifdef ROM_LOADER_CHECKSUM_EN
    push(8'hEA);
`endif
    wait_done("t5");
    chk("t5 addr", last_addr, 32'h0);
    chk("t5 data", last_data, 32'hD4C3B2A1);
    chk("t5 writes", 32'(wr_cnt - w0), 1);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Trailer match then mismatch
    start(1);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h0A);
    chk("t6 ok err", 32'(err_o), 0);
    wait_done("t6 ok");
    start(1);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h0B);
    chk("t6 bad err", 32'(err_o), 1);
    wait_done("t6 bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
